// File: rtl/dpi_timer_pkg.sv
// dpi_timer_pkg: shared types and width helpers for the DPI timer bank.
package dpi_timer_pkg;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_TS_W = 64;
  typedef logic [DEF_TS_W-1:0] ts_t;
  typedef logic [DEF_CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic [3:0] ch;
    cnt_t ncyc;
    logic periodic;
  } chan_req_t;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dpi_timer_channel.sv
// dpi_timer_channel: one cycle-wait channel, one-shot or periodic, stamping each expiry.
module dpi_timer_channel #(
  parameter int CNT_W = 32,
  parameter int TS_W = 64
) (
  input  logic             source_clock,
  input  logic             source_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] ncyc,
  input  logic             periodic,
  input  logic             cancel,
  input  logic [TS_W-1:0]  timemark,
  output logic             busy,
  output logic             done,
  output logic [TS_W-1:0]  stamp
);
  logic [CNT_W-1:0] cnt, reload, n1;
  logic [TS_W-1:0] tm_next;
  logic per;
  always_comb begin
    n1 = ncyc == '0 ? CNT_W'(1) : ncyc;
    tm_next = timemark + TS_W'(1);
  end
  // cancel outranks both a new load and a same-edge expiry
  always_ff @(posedge source_clock or posedge source_reset) begin
    if (source_reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      stamp <= '0;
      cnt <= '0;
      reload <= '0;
      per <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        busy <= 1'b0;
        cnt <= '0;
      end else if (load) begin
        busy <= periodic || ncyc != '0;
        cnt <= periodic ? n1 : ncyc;
        reload <= n1;
        per <= periodic;
        if (!periodic && ncyc == '0) begin
          done <= 1'b1;
          stamp <= tm_next;
        end
      end else if (busy) begin
        if (cnt == CNT_W'(1)) begin
          done <= 1'b1;
          stamp <= tm_next;
          busy <= per;
          cnt <= per ? reload : '0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/dpi_timer_bank.sv
// dpi_timer_bank: free-running timemark plus N_CH hardware wait channels armed by handshake.
module dpi_timer_bank
  import dpi_timer_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = 32,
  parameter int TS_W = 64,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic                 source_clock,
  input  logic                 source_reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CH_W-1:0]      req_ch,
  input  logic [CNT_W-1:0]     req_ncyc,
  input  logic                 req_periodic,
  input  logic [N_CH-1:0]      cancel,
  output logic [N_CH-1:0]      busy,
  output logic [N_CH-1:0]      done,
  output logic [N_CH*TS_W-1:0] done_stamp,
  output logic [TS_W-1:0]      timemark
);
  localparam int NP = 1 << CH_W;
  // padding to a full index range makes out-of-range channels read as not ready
  logic [NP-1:0] busy_p, cancel_p, valid_p;
  always_comb begin
    busy_p = NP'(busy);
    cancel_p = NP'(cancel);
    valid_p = NP'({N_CH{1'b1}});
    req_ready = valid_p[req_ch] && !busy_p[req_ch] && !cancel_p[req_ch];
  end
  always_ff @(posedge source_clock or posedge source_reset) begin
    if (source_reset) timemark <= '0;
    else timemark <= timemark + TS_W'(1);
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    dpi_timer_channel #(.CNT_W(CNT_W), .TS_W(TS_W)) u_ch (
      .source_clock(source_clock),
      .source_reset(source_reset),
      .load(req_valid && req_ready && req_ch == CH_W'(i)),
      .ncyc(req_ncyc),
      .periodic(req_periodic),
      .cancel(cancel[i]),
      .timemark(timemark),
      .busy(busy[i]),
      .done(done[i]),
      .stamp(done_stamp[i*TS_W +: TS_W])
    );
  end
endmodule

// File: tb/tb_dpi_timer_bank.sv
// tb_dpi_timer_bank: randomized and directed checks of two bank builds against an event-time model.
module tb_dpi_timer_bank;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_periodic = 1'b0;
  logic [1:0] req_ch = '0;
  logic [31:0] req_ncyc = '0;
  logic [N-1:0] cancel = '0;
  logic rdy_a, rdy_b;
  logic [N-1:0] busy_a, done_a, busy_b, done_b;
  logic [N*64-1:0] stamp_a;
  logic [N*8-1:0] stamp_b;
  logic [63:0] tm_a;
  logic [7:0] tm_b;
  dpi_timer_bank u_dut (
    .source_clock(clk), .source_reset(rst), .req_valid(req_valid), .req_ready(rdy_a),
    .req_ch(req_ch), .req_ncyc(req_ncyc), .req_periodic(req_periodic), .cancel(cancel),
    .busy(busy_a), .done(done_a), .done_stamp(stamp_a), .timemark(tm_a)
  );
  dpi_timer_bank #(.TS_W(8)) u_w8 (
    .source_clock(clk), .source_reset(rst), .req_valid(req_valid), .req_ready(rdy_b),
    .req_ch(req_ch), .req_ncyc(req_ncyc), .req_periodic(req_periodic), .cancel(cancel),
    .busy(busy_b), .done(done_b), .done_stamp(stamp_b), .timemark(tm_b)
  );
  // model: each armed channel remembers the absolute cycle of its next expiry
  longint unsigned t;
  bit m_busy[N], m_done[N];
  longint unsigned m_due[N], m_per[N], m_stamp[N];
  int errs = 0, checks = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0d", tag, got, exp, t);
    end
  endtask
  function automatic bit m_ready();
    return int'(req_ch) < N && !m_busy[req_ch] && !cancel[req_ch];
  endfunction
  task automatic model_reset();
    t = 0;
    for (int k = 0; k < N; k++) begin
      m_busy[k] = 0; m_done[k] = 0; m_due[k] = 0; m_per[k] = 0; m_stamp[k] = 0;
    end
  endtask
  task automatic model_edge();
    bit acc;
    longint unsigned n;
    acc = req_valid && m_ready();
    n = longint'(req_ncyc);
    t++;
    for (int k = 0; k < N; k++) begin
      m_done[k] = 0;
      if (cancel[k]) m_busy[k] = 0;
      else if (m_busy[k] && m_due[k] == t) begin
        m_done[k] = 1;
        m_stamp[k] = t;
        if (m_per[k] != 0) m_due[k] = t + m_per[k];
        else m_busy[k] = 0;
      end
      if (acc && int'(req_ch) == k) begin
        if (req_periodic) begin
          m_per[k] = n == 0 ? 1 : n;
          m_busy[k] = 1;
          m_due[k] = t + m_per[k];
        end else if (n == 0) begin
          m_done[k] = 1;
          m_stamp[k] = t;
        end else begin
          m_per[k] = 0;
          m_busy[k] = 1;
          m_due[k] = t + n;
        end
      end
    end
  endtask
  task automatic check_all();
    logic [N-1:0] eb, ed;
    for (int k = 0; k < N; k++) begin
      eb[k] = m_busy[k];
      ed[k] = m_done[k];
    end
    check("timemark", tm_a, t);
    check("timemark_w8", 64'(tm_b), 64'(t[7:0]));
    check("busy", 64'(busy_a), 64'(eb));
    check("busy_w8", 64'(busy_b), 64'(eb));
    check("done", 64'(done_a), 64'(ed));
    check("done_w8", 64'(done_b), 64'(ed));
    for (int k = 0; k < N; k++) begin
      check($sformatf("stamp%0d", k), stamp_a[k*64 +: 64], m_stamp[k]);
      check($sformatf("stamp%0d_w8", k), 64'(stamp_b[k*8 +: 8]), 64'(m_stamp[k][7:0]));
    end
  endtask
  task automatic cycle(input bit r, input bit v, input int ch, input int n, input bit per,
                       input logic [N-1:0] cn);
    @(negedge clk);
    rst = r;
    req_valid = v;
    req_ch = 2'(ch);
    req_ncyc = 32'(n);
    req_periodic = per;
    cancel = cn;
    #1;
    if (rst) model_reset();
    check("ready", 64'(rdy_a), 64'(m_ready()));
    check("ready_w8", 64'(rdy_b), 64'(m_ready()));
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all();
  endtask
  task automatic idle(input int c);
    repeat (c) cycle(0, 0, 0, 0, 0, '0);
  endtask
  initial begin
    model_reset();
    #1;
    check_all();
    repeat (5) cycle(1, 0, 0, 0, 0, '0);
    idle(20);
    idle(99 - int'(t));
    cycle(0, 1, 0, 10, 0, '0);
    idle(14);
    cycle(0, 1, 1, 3, 1, '0);
    idle(11);
    cycle(0, 0, 0, 0, 0, 4'b0010);
    idle(5);
    cycle(0, 1, 2, 0, 0, '0);
    cycle(0, 1, 2, 5, 0, '0);
    repeat (7) cycle(0, 1, 2, 1, 0, '0);
    idle(4);
    for (int k = 0; k < N; k++) cycle(0, 1, k, 7, 0, '0);
    idle(10);
    for (int k = 0; k < N; k++) cycle(0, 1, k, 10 - k, 0, '0);
    idle(12);
    cycle(0, 1, 3, 1, 1, '0);
    idle(5);
    cycle(0, 0, 0, 0, 0, 4'b1000);
    cycle(0, 0, 0, 0, 0, 4'b0001);
    idle(2);
    repeat (1500) begin
      logic [N-1:0] cn;
      cn = $urandom_range(0, 9) == 0 ? N'($urandom) : '0;
      cycle(0, $urandom_range(0, 2) != 0, int'($urandom_range(0, N - 1)),
            $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6)),
            $urandom_range(0, 2) == 0, cn);
    end
    idle(50);
    cycle(0, 1, 0, 20, 0, '0);
    cycle(0, 1, 1, 6, 1, '0);
    idle(4);
    cycle(1, 0, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, 0, '0);
    idle(30);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
